// File: rtl/tl_pkg.sv
// Shared light encodings, lamp-bundle payload, monitor states and fault codes
// for the T-intersection light conflict monitor.
package tl_pkg;

  localparam int unsigned LIGHT_W = 3;
  localparam int unsigned CODE_W  = 3;

  typedef logic [LIGHT_W-1:0] light_t;
  typedef logic [CODE_W-1:0]  code_t;

  localparam light_t RED    = 3'b100;
  localparam light_t YELLOW = 3'b010;
  localparam light_t GREEN  = 3'b001;
  localparam light_t OFF    = 3'b000;

  typedef struct packed {
    light_t m1;
    light_t m2;
    light_t m1_turn;
    light_t side;
  } lights_t;

  localparam lights_t ALL_RED = {RED, RED, RED, RED};
  localparam lights_t ALL_OFF = {OFF, OFF, OFF, OFF};

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  localparam code_t FC_NONE         = 3'd0;
  localparam code_t FC_ENCODING     = 3'd1;
  localparam code_t FC_CONFLICT     = 3'd2;
  localparam code_t FC_SKIP_YELLOW  = 3'd3;
  localparam code_t FC_SHORT_YELLOW = 3'd4;

  function automatic logic is_one_hot_light(input light_t l);
    return (l == RED) || (l == YELLOW) || (l == GREEN);
  endfunction

endpackage

// File: rtl/approach_seq_check.sv
// Per-approach phase-sequence checker: flags GREEN->RED (skipped yellow) and
// YELLOW->RED after too few yellow cycles, in the same cycle as the red input.
module approach_seq_check
  import tl_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  output logic       skip_yellow_c,
  output logic       short_yellow_c
);

  localparam int unsigned YC_W = $clog2(MIN_YELLOW + 1);

  logic [2:0]      prev_q;
  logic [YC_W-1:0] ycnt_q;

  // Previous input and saturating count of consecutive yellow samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= RED;
      ycnt_q <= '0;
    end else begin
      prev_q <= light;
      if (light == YELLOW) begin
        if (ycnt_q != YC_W'(MIN_YELLOW)) ycnt_q <= ycnt_q + YC_W'(1);
      end else begin
        ycnt_q <= '0;
      end
    end
  end

  assign skip_yellow_c  = (prev_q == GREEN) && (light == RED);
  assign short_yellow_c = (prev_q == YELLOW) && (light == RED) &&
                          (ycnt_q < YC_W'(MIN_YELLOW));

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety stage between the light controller and the lamps: passes legal light
// vectors through registered, otherwise forces all-red and latches flashing red.
module light_conflict_monitor
  import tl_pkg::*;
#(
  parameter int unsigned CONFIRM    = 2,
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned STARTUP    = 8,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_M1Turn,
  input  logic [2:0] light_Side,
  input  logic       fault_clr,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_M1Turn,
  output logic [2:0] lamp_Side,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned CNT_MAX = (STARTUP > 2 * FLASH_HALF) ? STARTUP : 2 * FLASH_HALF;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PER_W   = $clog2(CONFIRM + 1);

  lights_t          in_c;
  lights_t          lamps_d, lamps_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] persist_q, persist_d;
  logic             fault_q, fault_d;
  code_t            code_q, code_d;

  logic [3:0] skip_c, short_c;
  logic       bad_enc_c, conflict_c, seq_fault_c, all_red_c;
  code_t      cause_c;

  assign in_c = {light_M1, light_M2, light_M1Turn, light_Side};

  approach_seq_check #(.MIN_YELLOW(MIN_YELLOW)) u_seq_m1 (
    .clk(clk), .rst(rst), .light(light_M1),
    .skip_yellow_c(skip_c[0]), .short_yellow_c(short_c[0])
  );
  approach_seq_check #(.MIN_YELLOW(MIN_YELLOW)) u_seq_m2 (
    .clk(clk), .rst(rst), .light(light_M2),
    .skip_yellow_c(skip_c[1]), .short_yellow_c(short_c[1])
  );
  approach_seq_check #(.MIN_YELLOW(MIN_YELLOW)) u_seq_m1_turn (
    .clk(clk), .rst(rst), .light(light_M1Turn),
    .skip_yellow_c(skip_c[2]), .short_yellow_c(short_c[2])
  );
  approach_seq_check #(.MIN_YELLOW(MIN_YELLOW)) u_seq_side (
    .clk(clk), .rst(rst), .light(light_Side),
    .skip_yellow_c(skip_c[3]), .short_yellow_c(short_c[3])
  );

  // Instantaneous legality of the current vector and its highest-priority cause.
  always_comb begin
    bad_enc_c   = !is_one_hot_light(in_c.m1) || !is_one_hot_light(in_c.m2) ||
                  !is_one_hot_light(in_c.m1_turn) || !is_one_hot_light(in_c.side);
    conflict_c  = ((in_c.side != RED) &&
                   ((in_c.m1 != RED) || (in_c.m2 != RED) || (in_c.m1_turn != RED))) ||
                  ((in_c.m2 != RED) && (in_c.m1_turn != RED));
    seq_fault_c = (|skip_c) || (|short_c);
    all_red_c   = (in_c == ALL_RED);
    cause_c     = FC_NONE;
    if (bad_enc_c)        cause_c = FC_ENCODING;
    else if (conflict_c)  cause_c = FC_CONFLICT;
    else if (|skip_c)     cause_c = FC_SKIP_YELLOW;
    else if (|short_c)    cause_c = FC_SHORT_YELLOW;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_STARTUP;
      cnt_q     <= '0;
      persist_q <= '0;
      fault_q   <= 1'b0;
      code_q    <= FC_NONE;
      lamps_q   <= ALL_RED;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      persist_q <= persist_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      lamps_q   <= lamps_d;
    end
  end

  // Next state; cnt is the startup timer in STARTUP and the flash phase in FAULT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    persist_d = persist_q;
    fault_d   = fault_q;
    code_d    = code_q;
    unique case (state_q)
      ST_STARTUP: begin
        persist_d = '0;
        if (cnt_q == CNT_W'(STARTUP - 1)) begin
          state_d = ST_PASS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PASS: begin
        if (seq_fault_c ||
            ((bad_enc_c || conflict_c) && (persist_q == PER_W'(CONFIRM - 1)))) begin
          state_d   = ST_FAULT;
          fault_d   = 1'b1;
          code_d    = cause_c;
          cnt_d     = '0;
          persist_d = '0;
        end else if (bad_enc_c || conflict_c) begin
          persist_d = persist_q + PER_W'(1);
        end else begin
          persist_d = '0;
        end
      end
      ST_FAULT: begin
        if (fault_clr && all_red_c) begin
          state_d = ST_STARTUP;
          fault_d = 1'b0;
          code_d  = FC_NONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(2 * FLASH_HALF - 1)) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STARTUP;
        cnt_d   = '0;
      end
    endcase
  end

  // Next lamp drive.
  always_comb begin
    lamps_d = ALL_RED;
    unique case (state_q)
      ST_PASS: begin
        if (!(bad_enc_c || conflict_c || seq_fault_c)) lamps_d = in_c;
      end
      ST_FAULT: begin
        if (!(fault_clr && all_red_c) && (cnt_q >= CNT_W'(FLASH_HALF))) lamps_d = ALL_OFF;
      end
      default: lamps_d = ALL_RED;
    endcase
  end

  assign lamp_M1     = lamps_q.m1;
  assign lamp_M2     = lamps_q.m2;
  assign lamp_M1Turn = lamps_q.m1_turn;
  assign lamp_Side   = lamps_q.side;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed, table-driven bench for light_conflict_monitor with hand-computed
// lamp/fault expectations per clock edge.
module tb_light_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;
  localparam logic [2:0] B = 3'b011;

  typedef struct {
    string       tag;
    logic [2:0]  m1, m2, t, s;
    logic        clr;
    logic [11:0] exp_lamps;
    logic        exp_fault;
    logic [2:0]  exp_code;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] light_M1, light_M2, light_M1Turn, light_Side;
  logic       fault_clr;
  logic [2:0] lamp_M1, lamp_M2, lamp_M1Turn, lamp_Side;
  logic       fault;
  logic [2:0] fault_code;

  int   n_total  = 0;
  int   n_passed = 0;
  vec_t vecs[$];

  light_conflict_monitor dut (
    .clk(clk), .rst(rst),
    .light_M1(light_M1), .light_M2(light_M2),
    .light_M1Turn(light_M1Turn), .light_Side(light_Side),
    .fault_clr(fault_clr),
    .lamp_M1(lamp_M1), .lamp_M2(lamp_M2),
    .lamp_M1Turn(lamp_M1Turn), .lamp_Side(lamp_Side),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input string tag,
                     input logic [2:0] m1, input logic [2:0] m2,
                     input logic [2:0] t, input logic [2:0] s, input logic clr,
                     input logic [11:0] el, input logic ef, input logic [2:0] ec);
    vec_t v;
    v.tag = tag; v.m1 = m1; v.m2 = m2; v.t = t; v.s = s; v.clr = clr;
    v.exp_lamps = el; v.exp_fault = ef; v.exp_code = ec;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic drive(input logic [2:0] m1, input logic [2:0] m2,
                       input logic [2:0] t, input logic [2:0] s, input logic clr);
    light_M1 = m1; light_M2 = m2; light_M1Turn = t; light_Side = s; fault_clr = clr;
  endtask

  task automatic check(input string tag, input logic [11:0] el,
                       input logic ef, input logic [2:0] ec);
    logic [11:0] got;
    got = {lamp_M1, lamp_M2, lamp_M1Turn, lamp_Side};
    n_total++;
    if (got !== el || fault !== ef || fault_code !== ec)
      $display("FAIL %s: lamps=%b fault=%b code=%0d, expected lamps=%b fault=%b code=%0d",
               tag, got, fault, fault_code, el, ef, ec);
    else
      n_passed++;
  endtask

  initial begin
    // Startup boundary: 8th edge still red even with green requested.
    add(7, "startup",    R, R, R, R, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "startup_end", G, G, R, R, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(3, "pass_mm",    G, G, R, R, 1'b0, {G, G, R, R}, 1'b0, 3'd0);
    add(3, "pass_yy",    Y, Y, R, R, 1'b0, {Y, Y, R, R}, 1'b0, 3'd0);
    add(1, "confl_1cyc", Y, Y, R, G, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "side_only",  R, R, R, G, 1'b0, {R, R, R, G}, 1'b0, 3'd0);
    add(3, "side_yel",   R, R, R, Y, 1'b0, {R, R, R, Y}, 1'b0, 3'd0);
    add(1, "all_red",    R, R, R, R, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "turn_grn",   R, R, G, R, 1'b0, {R, R, G, R}, 1'b0, 3'd0);
    add(3, "turn_yel3",  R, R, Y, R, 1'b0, {R, R, Y, R}, 1'b0, 3'd0);
    add(1, "turn_red_ok", R, R, R, R, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "m1_grn",     G, R, R, R, 1'b0, {G, R, R, R}, 1'b0, 3'd0);
    add(1, "confl_p1",   G, R, R, G, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "confl_latch", G, R, R, G, 1'b0, {R, R, R, R}, 1'b1, 3'd2);
    add(4, "flash_red",  G, R, R, G, 1'b0, {R, R, R, R}, 1'b1, 3'd2);
    add(4, "flash_off",  G, R, R, G, 1'b0, {O, O, O, O}, 1'b1, 3'd2);
    add(1, "flash_red2", G, R, R, G, 1'b0, {R, R, R, R}, 1'b1, 3'd2);
    add(2, "clr_ignored", G, R, R, G, 1'b1, {R, R, R, R}, 1'b1, 3'd2);
    add(1, "clr_taken",  R, R, R, R, 1'b1, {R, R, R, R}, 1'b0, 3'd0);
    add(7, "restart",    R, R, R, R, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "restart_end", G, R, R, R, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "pass_m1",    G, R, R, R, 1'b0, {G, R, R, R}, 1'b0, 3'd0);
    add(1, "turn_grn2",  G, R, G, R, 1'b0, {G, R, G, R}, 1'b0, 3'd0);
    add(2, "turn_yel2",  G, R, Y, R, 1'b0, {G, R, Y, R}, 1'b0, 3'd0);
    add(1, "short_yel",  G, R, R, R, 1'b0, {R, R, R, R}, 1'b1, 3'd4);
    add(4, "sy_flash",   G, R, R, R, 1'b0, {R, R, R, R}, 1'b1, 3'd4);
    add(1, "sy_off",     G, R, R, R, 1'b0, {O, O, O, O}, 1'b1, 3'd4);
    add(1, "sy_clr",     R, R, R, R, 1'b1, {R, R, R, R}, 1'b0, 3'd0);
    add(7, "restart2",   R, R, R, R, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "restart2_e", G, R, R, R, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "pass_m1b",   G, R, R, R, 1'b0, {G, R, R, R}, 1'b0, 3'd0);
    add(1, "skip_yel",   R, R, R, R, 1'b0, {R, R, R, R}, 1'b1, 3'd3);
    add(1, "skip_clr",   R, R, R, R, 1'b1, {R, R, R, R}, 1'b0, 3'd0);
    add(7, "restart3",   R, R, R, R, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "restart3_e", R, G, R, R, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "pass_m2",    R, G, R, R, 1'b0, {R, G, R, R}, 1'b0, 3'd0);
    add(1, "enc_p1",     R, B, G, R, 1'b0, {R, R, R, R}, 1'b0, 3'd0);
    add(1, "enc_prio",   R, B, G, R, 1'b0, {R, R, R, R}, 1'b1, 3'd1);
    add(4, "enc_flash",  R, B, G, R, 1'b0, {R, R, R, R}, 1'b1, 3'd1);
    add(1, "enc_off",    R, B, G, R, 1'b0, {O, O, O, O}, 1'b1, 3'd1);

    rst = 1'b0;
    drive(R, R, R, R, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset", {R, R, R, R}, 1'b0, 3'd0);

    @(negedge clk);
    rst = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].m1, vecs[i].m2, vecs[i].t, vecs[i].s, vecs[i].clr);
      @(posedge clk);
      #1;
      check(vecs[i].tag, vecs[i].exp_lamps, vecs[i].exp_fault, vecs[i].exp_code);
      @(negedge clk);
    end

    // Asynchronous reset in the dark half of the flash.
    rst = 1'b0;
    #1;
    check("rst_midflash", {R, R, R, R}, 1'b0, 3'd0);
    drive(R, R, R, R, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(G, R, R, R, 1'b0);
      @(posedge clk);
      #1;
      if (i < 8) check("post_rst_startup", {R, R, R, R}, 1'b0, 3'd0);
      else       check("post_rst_pass", {G, R, R, R}, 1'b0, 3'd0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
